// File: rtl/alu_result_stage.sv
// EX-stage result selector: picks the function-unit result named by op, applies
// overflow writeback suppression, and buffers it in a 2-entry valid/ready FIFO.
module alu_result_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [DW-1:0] Rand,
  input  logic [DW-1:0] Ror,
  input  logic [DW-1:0] Radd,
  input  logic [DW-1:0] Rsub,
  input  logic          add_ovf,
  input  logic          sub_ovf,
  input  logic          sub_borrow,
  input  logic [AW-1:0] in_rd,
  input  logic          in_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_zero,
  output logic          out_ovf,
  output logic [AW-1:0] out_rd,
  output logic          out_we
);

  localparam logic [2:0] OP_AND = 3'd0, OP_OR  = 3'd1, OP_ADD = 3'd2, OP_SUB  = 3'd3,
                         OP_SLT = 3'd4, OP_NOR = 3'd5, OP_XOR = 3'd6, OP_SLTU = 3'd7;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          zero;
    logic          ovf;
    logic [AW-1:0] rd;
    logic          we;
  } entry_t;

  entry_t     new_ent;
  entry_t     ent0_q, ent0_d;  // ent0 is always the head
  entry_t     ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       push, pop;

  always_comb begin
    new_ent = '0;
    case (op)
      OP_AND:  new_ent.result = Rand;
      OP_OR:   new_ent.result = Ror;
      OP_ADD:  new_ent.result = Radd;
      OP_SUB:  new_ent.result = Rsub;
      OP_SLT:  new_ent.result = {{(DW-1){1'b0}}, Rsub[DW-1] ^ sub_ovf};
      OP_NOR:  new_ent.result = ~Ror;
      OP_XOR:  new_ent.result = Ror & ~Rand;
      OP_SLTU: new_ent.result = {{(DW-1){1'b0}}, sub_borrow};
      default: new_ent.result = '0;
    endcase
    new_ent.ovf  = (op == OP_ADD) ? add_ovf : (op == OP_SUB) ? sub_ovf : 1'b0;
    new_ent.zero = (new_ent.result == '0);
    new_ent.rd   = in_rd;
    // trapping ops keep their result for the exception path but never write back
    new_ent.we   = in_we & ~new_ent.ovf;
  end

  assign in_ready  = (cnt_q != 2'd2) & ~rst & ~flush;
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (rst) begin
      ent0_d = '0;
      ent1_d = '0;
      cnt_d  = 2'd0;
    end else if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: if (push) begin
          ent0_d = new_ent;
          cnt_d  = 2'd1;
        end
        2'd1: begin
          if (push && pop) begin
            ent0_d = new_ent;
          end else if (push) begin
            ent1_d = new_ent;
            cnt_d  = 2'd2;
          end else if (pop) begin
            cnt_d = 2'd0;
          end
        end
        2'd2: if (pop) begin
          ent0_d = ent1_q;
          cnt_d  = 2'd1;
        end
        default: cnt_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
    cnt_q  <= cnt_d;
  end

  assign out_result = ent0_q.result;
  assign out_zero   = ent0_q.zero;
  assign out_ovf    = ent0_q.ovf;
  assign out_rd     = ent0_q.rd;
  assign out_we     = ent0_q.we;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Downstream EX-stage block that consumes the 32-bit function-unit results (AND, OR, ADD, SUB with their flags), selects the one named by the decoded opcode, and derives NOR/XOR/SLT/SLTU from them. Applies the overflow writeback-suppression rule and registers result, flags and destination into a 2-entry output buffer. Presents them to the MEM/WB side over a valid/ready handshake, decoupling the ALU from writeback stalls.

## Interface
- DW, 32, datapath width
- AW, 5, register-file address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush; empties the buffer
- in_valid  in  1  upstream holds a valid operation
- in_ready  out  1  stage can accept this cycle
- op  in  3  0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 NOR, 6 XOR, 7 SLTU
- Rand  in  DW  a & b
- Ror  in  DW  a | b
- Radd  in  DW  a + b (mod 2^DW)
- Rsub  in  DW  a - b (mod 2^DW)
- add_ovf  in  1  signed overflow of a+b
- sub_ovf  in  1  signed overflow of a-b
- sub_borrow  in  1  unsigned a < b
- in_rd  in  AW  destination register
- in_we  in  1  writeback requested
- out_valid  out  1  buffer head valid
- out_ready  in  1  downstream accepts head
- out_result  out  DW  selected result
- out_zero  out  1  out_result == 0
- out_ovf  out  1  arithmetic overflow trap (ADD/SUB only)
- out_rd  out  AW  destination register
- out_we  out  1  writeback enable after trap suppression

## Operation
- Result select: AND→Rand; OR→Ror; ADD→Radd; SUB→Rsub; NOR→~Ror; XOR→Ror & ~Rand; SLT→{31'b0, Rsub[DW-1]^sub_ovf}; SLTU→{31'b0, sub_borrow}.
- ovf = add_ovf when op=ADD, sub_ovf when op=SUB, else 0. SLT/SLTU never trap.
- we = in_we & ~ovf. A trapping op stays in the buffer with out_ovf=1, out_we=0, and out_result unchanged, for exception logic.
- zero computed from the selected result before buffering.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Buffer: 2 entries with count 0..2.
  - in_ready = (count != 2) & ~rst & ~flush.
  - out_valid = (count != 0).
  - Head entry drives all out_* fields.
- Count state transitions:
  - 0: push → 1.
  - 1: push only → 2; pop only → 0; push+pop → 1, new entry becomes head next cycle.
  - 2: pop → 1. No push is possible.
- Ordering strictly FIFO. Head fields stay stable while out_valid=1 and out_ready=0.
- flush: count → 0 next edge. Concurrent push and pop are discarded. flush has priority over both.
- rst: same effect as flush; it also zeroes all stored entries.

## Timing
- Reset values: out_valid=0, out_result=0, out_zero=0, out_ovf=0, out_rd=0, out_we=0; in_ready=0 while rst=1 and 1 on the first cycle after.
- Latency: op accepted at edge N appears on out_* after edge N with out_valid=1, i.e. 1 cycle.
- Throughput: 1 op/cycle while out_ready=1. in_ready never depends combinationally on out_ready; it depends on count only.
- When count=2 and a pop occurs at edge N, in_ready rises after edge N, i.e. a 1-cycle bubble upstream.
- Empty-buffer out_* fields hold last-popped values (don't-care); out_valid=0 governs.
- Reset or flush mid-burst: no entry accepted or held before the edge survives it.

## Test plan
- Reset then single ops: Rand=0x0000F0F0 with op=0 → out_result 0x0000F0F0 one cycle later, out_zero=0. Ror=0x0000FFFF with op=5 → 0xFFFF0000. Rand=0x0F, Ror=0xFF with op=6 → 0xF0.
- SLT/SLTU: Rsub=0x80000001, sub_ovf=1, op=4 → result 0. op=7 with sub_borrow=1 → 1, out_ovf=0. op=4 with Rsub=0, sub_ovf=0 → result 0, out_zero=1.
- Overflow: op=2, Radd=0x80000000, add_ovf=1, in_we=1, in_rd=5 → out_ovf=1, out_we=0, out_rd=5, out_result=0x80000000.
- Backpressure: out_ready=0, push ops A,B,C back-to-back → A and B accepted, in_ready=0 during C, head stays A. Raise out_ready → A, B, C exit in order with a single upstream bubble.
- Simultaneous push/pop at count=1 over 10 consecutive ops with out_ready=1 → one result per cycle, count stays 1, no loss or duplication.
- Flush with count=2 and concurrent push → out_valid=0 next cycle, no pushed entry appears. Repeat the same sequence with rst instead of flush → all out_* fields = 0.
